// File: rtl/fpu_pkg.sv
// Shared types and constants for the parametrised floating-point multiplier.
// Build option: FPU_MUL_SUBNORMAL_EN enables gradual underflow in the multiplier.
package fpu_pkg;

    typedef enum logic [1:0] {
        RNE = 2'd0,
        RTZ = 2'd1,
        RUP = 2'd2,
        RDN = 2'd3
    } rnd_mode_t;

    typedef enum logic [3:0] {
        ST_GET,
        ST_UNPACK,
        ST_SPECIAL,
        ST_NORM_IN,
        ST_MULT,
        ST_NORM_OUT,
        ST_ROUND,
        ST_PACK,
        ST_PUT
    } state_t;

    // Bit positions inside the {invalid, overflow, underflow, inexact} flag word
    localparam int FLG_NV = 3;
    localparam int FLG_OF = 2;
    localparam int FLG_UF = 1;
    localparam int FLG_NX = 0;

    // Canonical quiet NaN {1, all-ones exponent, 1, zeros}, right-aligned in 64 bits
    function automatic logic [63:0] qnan(input int exp_w, input int frac_w);
        logic [63:0] v;
        v = ((64'd1 << (exp_w + 1)) - 64'd1) << frac_w;
        v = v | (64'd1 << (frac_w - 1));
        return v;
    endfunction

    // Largest finite magnitude (sign bit excluded), right-aligned in 64 bits
    function automatic logic [63:0] max_finite(input int exp_w, input int frac_w);
        return (((64'd1 << exp_w) - 64'd2) << frac_w) | ((64'd1 << frac_w) - 64'd1);
    endfunction

endpackage

// File: rtl/fpu_mul_round.sv
// Combinational rounding stage: applies the selected rounding mode to the
// normalised mantissa and reports overflow of the rounded exponent.
module fpu_mul_round
    import fpu_pkg::*;
#(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23
) (
    input  logic [FRAC_W:0]         man_in,
    input  logic                    guard_in,
    input  logic                    round_in,
    input  logic                    sticky_in,
    input  logic                    sign_in,
    input  rnd_mode_t               mode_in,
    input  logic signed [EXP_W+1:0] exp_in,
    output logic [FRAC_W:0]         man_out,
    output logic signed [EXP_W+1:0] exp_out,
    output logic                    overflow,
    output logic                    inexact
);
    localparam int EW = EXP_W + 2;
    localparam logic signed [EW-1:0] BIAS = EW'((1 << (EXP_W - 1)) - 1);

    logic            inc;
    logic            lost;
    logic [FRAC_W+1:0] sum;

    // Increment decision, carry-out renormalisation and overflow detection
    always_comb begin
        lost = guard_in | round_in | sticky_in;
        inc  = 1'b0;
        case (mode_in)
            RNE:     inc = guard_in & (round_in | sticky_in | man_in[0]);
            RTZ:     inc = 1'b0;
            RUP:     inc = lost & ~sign_in;
            RDN:     inc = lost & sign_in;
            default: inc = 1'b0;
        endcase
        sum = {1'b0, man_in} + {{(FRAC_W + 1){1'b0}}, inc};
        if (sum[FRAC_W+1]) begin
            man_out = sum[FRAC_W+1:1];
            exp_out = exp_in + EW'(1);
        end else begin
            man_out = sum[FRAC_W:0];
            exp_out = exp_in;
        end
        overflow = exp_out > BIAS;
        inexact  = lost;
    end

endmodule

// File: rtl/fpu_multiplier_param.sv
// Multi-cycle IEEE-754 multiplier with generic exponent/fraction widths,
// stb/ack operand and result channels and per-operation rounding mode.
// Build option: FPU_MUL_SUBNORMAL_EN (gradual underflow; otherwise flush to zero).
module fpu_multiplier_param
    import fpu_pkg::*;
#(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [EXP_W+FRAC_W:0]   input_a,
    input  logic [EXP_W+FRAC_W:0]   input_b,
    input  logic [1:0]              input_rnd,
    input  logic                    input_stb,
    output logic                    input_ack,
    output logic [EXP_W+FRAC_W:0]   output_z,
    output logic [3:0]              output_flags,
    output logic                    output_z_stb,
    input  logic                    output_z_ack
);
    localparam int W  = 1 + EXP_W + FRAC_W;
    localparam int M  = FRAC_W + 1;
    localparam int EW = EXP_W + 2;
    localparam int PW = 2 * M;
    localparam logic signed [EW-1:0] BIAS = EW'((1 << (EXP_W - 1)) - 1);
    localparam logic signed [EW-1:0] EMIN = EW'(1) - BIAS;
    localparam logic [63:0] QNAN_ALL = qnan(EXP_W, FRAC_W);
    localparam logic [63:0] MAXF_ALL = max_finite(EXP_W, FRAC_W);
    localparam logic [W-1:0] QNAN    = QNAN_ALL[W-1:0];
    localparam logic [W-2:0] MAXF    = MAXF_ALL[W-2:0];
    localparam logic [EXP_W-1:0] EXP_ONES = '1;
    localparam logic [W-2:0] INF_MAG = {EXP_ONES, {FRAC_W{1'b0}}};

    state_t            state_reg, state_next;
    logic [W-1:0]      op_reg [2];
    rnd_mode_t         rnd_reg;
    logic [M-1:0]      man_reg [2];
    logic signed [EW-1:0] exp_reg [2];
    logic [PW-1:0]     prod_reg;
    logic signed [EW-1:0] zexp_reg;
    logic              sticky_reg, tiny_reg;
    logic [M-1:0]      rman_reg;
    logic signed [EW-1:0] rexp_reg;
    logic              rovf_reg, rnx_reg;

    logic [EXP_W-1:0]  efld [2];
    logic [FRAC_W-1:0] ffld [2];
    logic [1:0]        cls_nan, cls_snan, cls_inf, cls_zero;
    logic [M-1:0]      unp_man [2];
    logic signed [EW-1:0] unp_exp [2];
    logic              res_sign, xfer;

    // Per-operand field split, classification and unpacking
    for (genvar gi = 0; gi < 2; gi++) begin : g_unpack
        assign efld[gi]     = op_reg[gi][W-2:FRAC_W];
        assign ffld[gi]     = op_reg[gi][FRAC_W-1:0];
        assign cls_nan[gi]  = (efld[gi] == EXP_ONES) && (ffld[gi] != '0);
        assign cls_snan[gi] = cls_nan[gi] && !ffld[gi][FRAC_W-1];
        assign cls_inf[gi]  = (efld[gi] == EXP_ONES) && (ffld[gi] == '0);
`ifdef FPU_MUL_SUBNORMAL_EN
        assign cls_zero[gi] = (efld[gi] == '0) && (ffld[gi] == '0);
        assign unp_man[gi]  = {(efld[gi] != '0), ffld[gi]};
        assign unp_exp[gi]  = (efld[gi] == '0) ? EMIN : ($signed({2'b00, efld[gi]}) - BIAS);
`else
        // Subnormal encodings collapse onto signed zero
        assign cls_zero[gi] = (efld[gi] == '0);
        assign unp_man[gi]  = {1'b1, ffld[gi]};
        assign unp_exp[gi]  = $signed({2'b00, efld[gi]}) - BIAS;
`endif
    end

    assign res_sign = op_reg[0][W-1] ^ op_reg[1][W-1];
    assign xfer     = (state_reg == ST_GET) && input_ack && input_stb;

    logic           special_hit;
    logic [W-1:0]   special_z;
    logic [3:0]     special_flags;

    // Special-operand resolution (NaN, infinity, zero)
    always_comb begin
        special_hit   = 1'b1;
        special_z     = '0;
        special_flags = '0;
        if (|cls_nan) begin
            special_z             = QNAN;
            special_flags[FLG_NV] = |cls_snan;
        end else if ((cls_inf[0] && cls_zero[1]) || (cls_inf[1] && cls_zero[0])) begin
            special_z             = QNAN;
            special_flags[FLG_NV] = 1'b1;
        end else if (|cls_inf) begin
            special_z = {res_sign, INF_MAG};
        end else if (|cls_zero) begin
            special_z = {res_sign, {(W - 1){1'b0}}};
        end else begin
            special_hit = 1'b0;
        end
    end

    logic           norm_in_done;
    assign norm_in_done = man_reg[0][M-1] & man_reg[1][M-1];

    logic [PW-1:0]  p_n;
    logic signed [EW-1:0] e_n;
    logic           s_n, t_n, norm_more;

    // One product normalisation step; norm_more says whether another is needed
    always_comb begin
        p_n = prod_reg;
        e_n = zexp_reg;
        s_n = sticky_reg;
        t_n = tiny_reg;
        if (!tiny_reg && !prod_reg[PW-1]) begin
            p_n = {prod_reg[PW-2:0], 1'b0};
            e_n = zexp_reg - EW'(1);
        end
`ifdef FPU_MUL_SUBNORMAL_EN
        else if (zexp_reg < EMIN) begin
            p_n = {1'b0, prod_reg[PW-1:1]};
            e_n = zexp_reg + EW'(1);
            s_n = sticky_reg | prod_reg[0];
            t_n = 1'b1;
        end
        norm_more = (!t_n && !p_n[PW-1]) || (e_n < EMIN);
`else
        norm_more = !p_n[PW-1];
        t_n       = !norm_more && (e_n < EMIN);
`endif
    end

    logic [M-1:0]   rnd_man;
    logic signed [EW-1:0] rnd_exp;
    logic           rnd_ovf, rnd_nx;

    fpu_mul_round #(.EXP_W(EXP_W), .FRAC_W(FRAC_W)) u_round (
        .man_in    (prod_reg[PW-1:M]),
        .guard_in  (prod_reg[M-1]),
        .round_in  (prod_reg[M-2]),
        .sticky_in ((|prod_reg[M-3:0]) | sticky_reg),
        .sign_in   (res_sign),
        .mode_in   (rnd_reg),
        .exp_in    (zexp_reg),
        .man_out   (rnd_man),
        .exp_out   (rnd_exp),
        .overflow  (rnd_ovf),
        .inexact   (rnd_nx)
    );

    logic [W-1:0]   pack_z;
    logic [3:0]     pack_flags;

    // Final encoding: overflow saturation per mode, flush or normal/subnormal pack
    always_comb begin
        pack_z     = '0;
        pack_flags = '0;
        if (rovf_reg) begin
            pack_flags[FLG_OF] = 1'b1;
            pack_flags[FLG_NX] = 1'b1;
            case (rnd_reg)
                RNE:     pack_z = {res_sign, INF_MAG};
                RTZ:     pack_z = {res_sign, MAXF};
                RUP:     pack_z = res_sign ? {1'b1, MAXF} : {1'b0, INF_MAG};
                RDN:     pack_z = res_sign ? {1'b1, INF_MAG} : {1'b0, MAXF};
                default: pack_z = {res_sign, INF_MAG};
            endcase
        end
`ifndef FPU_MUL_SUBNORMAL_EN
        else if (tiny_reg) begin
            pack_z             = {res_sign, {(W - 1){1'b0}}};
            pack_flags[FLG_UF] = 1'b1;
            pack_flags[FLG_NX] = 1'b1;
        end
`endif
        else begin
            pack_z = {res_sign,
                      rman_reg[M-1] ? EXP_W'(rexp_reg + BIAS) : {EXP_W{1'b0}},
                      rman_reg[M-2:0]};
            pack_flags[FLG_NX] = rnx_reg;
            pack_flags[FLG_UF] = tiny_reg & rnx_reg;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_reg <= ST_GET;
        else     state_reg <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_GET:      if (xfer) state_next = ST_UNPACK;
            ST_UNPACK:   state_next = ST_SPECIAL;
            ST_SPECIAL:  state_next = special_hit ? ST_PUT : ST_NORM_IN;
            ST_NORM_IN:  if (norm_in_done) state_next = ST_MULT;
            ST_MULT:     state_next = ST_NORM_OUT;
            ST_NORM_OUT: if (!norm_more) state_next = ST_ROUND;
            ST_ROUND:    state_next = ST_PACK;
            ST_PACK:     state_next = ST_PUT;
            ST_PUT:      if (output_z_stb && output_z_ack) state_next = ST_GET;
            default:     state_next = ST_GET;
        endcase
    end

    // Handshake and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            input_ack    <= 1'b0;
            output_z_stb <= 1'b0;
            output_z     <= '0;
            output_flags <= '0;
        end else begin
            case (state_reg)
                ST_GET: begin
                    if (!input_ack)     input_ack <= 1'b1;
                    else if (input_stb) input_ack <= 1'b0;
                end
                ST_SPECIAL: begin
                    if (special_hit) begin
                        output_z     <= special_z;
                        output_flags <= special_flags;
                        output_z_stb <= 1'b1;
                    end
                end
                ST_PACK: begin
                    output_z     <= pack_z;
                    output_flags <= pack_flags;
                    output_z_stb <= 1'b1;
                end
                ST_PUT: begin
                    if (output_z_stb && output_z_ack) begin
                        output_z_stb <= 1'b0;
                        input_ack    <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Arithmetic datapath registers
    always_ff @(posedge clk) begin
        case (state_reg)
            ST_GET: begin
                if (xfer) begin
                    op_reg[0] <= input_a;
                    op_reg[1] <= input_b;
                    rnd_reg   <= rnd_mode_t'(input_rnd);
                end
            end
            ST_UNPACK: begin
                for (int i = 0; i < 2; i++) begin
                    man_reg[i] <= unp_man[i];
                    exp_reg[i] <= unp_exp[i];
                end
                sticky_reg <= 1'b0;
                tiny_reg   <= 1'b0;
            end
`ifdef FPU_MUL_SUBNORMAL_EN
            ST_NORM_IN: begin
                for (int i = 0; i < 2; i++) begin
                    if (!man_reg[i][M-1]) begin
                        man_reg[i] <= {man_reg[i][M-2:0], 1'b0};
                        exp_reg[i] <= exp_reg[i] - EW'(1);
                    end
                end
            end
`endif
            ST_MULT: begin
                prod_reg <= PW'(man_reg[0]) * PW'(man_reg[1]);
                zexp_reg <= exp_reg[0] + exp_reg[1] + EW'(1);
            end
            ST_NORM_OUT: begin
                prod_reg   <= p_n;
                zexp_reg   <= e_n;
                sticky_reg <= s_n;
                tiny_reg   <= t_n;
            end
            ST_ROUND: begin
                rman_reg <= rnd_man;
                rexp_reg <= rnd_exp;
                rovf_reg <= rnd_ovf;
                rnx_reg  <= rnd_nx;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_fpu_multiplier_param.sv
// Directed bench for fpu_multiplier_param: single and half precision instances.
module tb_fpu_multiplier_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [31:0] a32, b32, z32;
    logic [1:0]  rnd32;
    logic        stb32, ack32, zstb32, zack32;
    logic [3:0]  fl32;
    logic [15:0] a16, b16, z16;
    logic [1:0]  rnd16;
    logic        stb16, ack16, zstb16, zack16;
    logic [3:0]  fl16;

    int vectors = 0;
    int miscompares = 0;

    fpu_multiplier_param #(.EXP_W(8), .FRAC_W(23)) u_sp (
        .clk(clk), .rst(rst),
        .input_a(a32), .input_b(b32), .input_rnd(rnd32),
        .input_stb(stb32), .input_ack(ack32),
        .output_z(z32), .output_flags(fl32),
        .output_z_stb(zstb32), .output_z_ack(zack32)
    );

    fpu_multiplier_param #(.EXP_W(5), .FRAC_W(10)) u_hp (
        .clk(clk), .rst(rst),
        .input_a(a16), .input_b(b16), .input_rnd(rnd16),
        .input_stb(stb16), .input_ack(ack16),
        .output_z(z16), .output_flags(fl16),
        .output_z_stb(zstb16), .output_z_ack(zack16)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic cur_ack(input bit h);
        return h ? ack16 : ack32;
    endfunction
    function automatic logic cur_zstb(input bit h);
        return h ? zstb16 : zstb32;
    endfunction
    function automatic logic [31:0] cur_z(input bit h);
        return h ? {16'd0, z16} : z32;
    endfunction
    function automatic logic [3:0] cur_fl(input bit h);
        return h ? fl16 : fl32;
    endfunction

    task automatic drive(input bit h, input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] rnd, input logic stb);
        if (h) begin a16 = a[15:0]; b16 = b[15:0]; rnd16 = rnd; stb16 = stb; end
        else   begin a32 = a;       b32 = b;       rnd32 = rnd; stb32 = stb; end
    endtask

    task automatic set_zack(input bit h, input logic v);
        if (h) zack16 = v;
        else   zack32 = v;
    endtask

    // One complete operation: transfer, latency, result, optional stall, release
    task automatic do_op(input bit h, input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] rnd, input logic [31:0] ez, input logic [3:0] ef,
                         input int elat, input int hold, input string tag);
        int n;
        n = 0;
        while (cur_ack(h) !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        check({tag, " ack_ready"}, {31'd0, cur_ack(h)}, 32'd1);
        drive(h, a, b, rnd, 1'b1);
        @(posedge clk); #1;
        drive(h, a, b, rnd, 1'b0);
        n = 0;
        while (cur_zstb(h) !== 1'b1 && n < 400) begin @(posedge clk); #1; n++; end
        check({tag, " stb"}, {31'd0, cur_zstb(h)}, 32'd1);
        if (elat > 0) check({tag, " latency"}, n, elat);
        check({tag, " z"}, cur_z(h), ez);
        check({tag, " flags"}, {28'd0, cur_fl(h)}, {28'd0, ef});
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check({tag, " hold_z"}, cur_z(h), ez);
            check({tag, " hold_flags"}, {28'd0, cur_fl(h)}, {28'd0, ef});
            check({tag, " hold_ack"}, {31'd0, cur_ack(h)}, 32'd0);
        end
        set_zack(h, 1'b1);
        @(posedge clk); #1;
        set_zack(h, 1'b0);
        check({tag, " stb_drop"}, {31'd0, cur_zstb(h)}, 32'd0);
        check({tag, " ack_back"}, {31'd0, cur_ack(h)}, 32'd1);
        $display("op %s: a=%h b=%h rnd=%0d z=%h flags=%b lat=%0d", tag, a, b, rnd, cur_z(h), cur_fl(h), n);
    endtask

    initial begin
        rst = 1'b1;
        a32 = '0; b32 = '0; rnd32 = 2'd0; stb32 = 1'b0; zack32 = 1'b0;
        a16 = '0; b16 = '0; rnd16 = 2'd0; stb16 = 1'b0; zack16 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset ack", {31'd0, ack32}, 32'd0);
        check("reset stb", {31'd0, zstb32}, 32'd0);
        check("reset z", z32, 32'd0);
        check("reset flags", {28'd0, fl32}, 32'd0);
        rst = 1'b0;

        do_op(0, 32'h40400000, 32'h40200000, 2'd0, 32'h40F00000, 4'b0000, 7, 0, "3x2.5_rne");
        do_op(0, 32'h7F800000, 32'h00000000, 2'd0, 32'hFFC00000, 4'b1000, 2, 0, "inf_x_zero");
        do_op(0, 32'h7FA00000, 32'h3F800000, 2'd0, 32'hFFC00000, 4'b1000, 2, 0, "snan_x_one");
        do_op(0, 32'h7FC00001, 32'h3F800000, 2'd0, 32'hFFC00000, 4'b0000, 2, 0, "qnan_x_one");
        do_op(0, 32'h7F800000, 32'hC0000000, 2'd0, 32'hFF800000, 4'b0000, 2, 0, "inf_x_neg2");
        do_op(0, 32'h80000000, 32'h40400000, 2'd0, 32'h80000000, 4'b0000, 2, 0, "negzero_x_3");
        do_op(0, 32'h7F7FFFFF, 32'h40000000, 2'd0, 32'h7F800000, 4'b0101, 7, 0, "ovf_rne");
        do_op(0, 32'h7F7FFFFF, 32'h40000000, 2'd1, 32'h7F7FFFFF, 4'b0101, 7, 0, "ovf_rtz");
        do_op(0, 32'hFF7FFFFF, 32'h40000000, 2'd2, 32'hFF7FFFFF, 4'b0101, 7, 0, "ovf_neg_rup");
        do_op(0, 32'hFF7FFFFF, 32'h40000000, 2'd3, 32'hFF800000, 4'b0101, 7, 0, "ovf_neg_rdn");
        do_op(0, 32'h3F800001, 32'h3F800001, 2'd0, 32'h3F800002, 4'b0001, 7, 0, "ulp_sq_rne");
        do_op(0, 32'h3F800001, 32'h3F800001, 2'd1, 32'h3F800002, 4'b0001, 7, 0, "ulp_sq_rtz");
        do_op(0, 32'h3F800001, 32'h3F800001, 2'd2, 32'h3F800003, 4'b0001, 7, 0, "ulp_sq_rup");
`ifdef FPU_MUL_SUBNORMAL_EN
        do_op(0, 32'h00800000, 32'h3F000000, 2'd0, 32'h00400000, 4'b0000, 8, 0, "tiny_half");
        do_op(0, 32'h00400000, 32'h40000000, 2'd0, 32'h00800000, 4'b0000, 0, 0, "subnorm_in_x2");
`else
        do_op(0, 32'h00800000, 32'h3F000000, 2'd0, 32'h00000000, 4'b0011, 7, 0, "tiny_half");
        do_op(0, 32'h00400000, 32'h40000000, 2'd0, 32'h00000000, 4'b0000, 2, 0, "subnorm_in_x2");
`endif
        do_op(0, 32'h40400000, 32'h40200000, 2'd0, 32'h40F00000, 4'b0000, 7, 5, "stall5");

        // Abort an operation while it sits in MULT
        while (ack32 !== 1'b1) @(negedge clk);
        drive(0, 32'h40400000, 32'h40200000, 2'd0, 1'b1);
        @(posedge clk); #1;
        drive(0, 32'h40400000, 32'h40200000, 2'd0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort stb", {31'd0, zstb32}, 32'd0);
        check("abort ack", {31'd0, ack32}, 32'd0);
        @(posedge clk); #1;
        check("abort stb1", {31'd0, zstb32}, 32'd0);
        @(posedge clk); #1;
        check("abort ack2", {31'd0, ack32}, 32'd1);
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            check("abort no_stb", {31'd0, zstb32}, 32'd0);
        end
        $display("op abort_in_mult: stb=%b ack=%b", zstb32, ack32);
        do_op(0, 32'h40400000, 32'h40200000, 2'd0, 32'h40F00000, 4'b0000, 7, 0, "after_abort");

        do_op(1, 32'h00003C00, 32'h00004000, 2'd0, 32'h00004000, 4'b0000, 7, 0, "half_1x2");
        do_op(1, 32'h00003E00, 32'h00003E00, 2'd0, 32'h00004080, 4'b0000, 7, 0, "half_1.5sq");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
